// File: rtl/ofdm_preamble_inserter.sv
// OFDM preamble inserter: prepends a repeating short-training preamble to each
// payload frame and appends an optional run of zero samples after it.
module ofdm_preamble_inserter #(
  parameter int unsigned WIDTH_SAMPLE = 16,
  parameter int unsigned PREAMBLE_LEN = 160,
  parameter int unsigned SYMBOL_LEN   = 16,
  parameter int unsigned SR_SYMBOL    = 5,
  parameter int unsigned SR_CTRL      = 6,
  parameter int unsigned SR_GAP       = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  // settings bus
  input  logic                      set_stb,
  input  logic [7:0]                set_addr,
  input  logic [31:0]               set_data,
  // payload sample stream
  input  logic [2*WIDTH_SAMPLE-1:0] i_tdata,
  input  logic                      i_tlast,
  input  logic                      i_tvalid,
  output logic                      i_tready,
  // framed TX sample stream
  output logic [2*WIDTH_SAMPLE-1:0] o_tdata,
  output logic                      o_tlast,
  output logic                      o_tvalid,
  input  logic                      o_tready
);

  localparam int unsigned DW = 2 * WIDTH_SAMPLE;
  localparam int unsigned CW = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
  localparam int unsigned SW = (SYMBOL_LEN > 1) ? $clog2(SYMBOL_LEN) : 1;
  localparam int unsigned GW = 16;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PREAMBLE = 2'd1;
  localparam logic [1:0] S_PAYLOAD  = 2'd2;
  localparam logic [1:0] S_GAP      = 2'd3;

  logic [1:0]    state_q,   state_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [SW-1:0] sidx_q,    sidx_d;
  logic [GW-1:0] gcnt_q,    gcnt_d;
  logic [GW-1:0] gap_lat_q, gap_lat_d;

  logic          enable_q;
  logic [GW-1:0] gap_q;
  logic [SW-1:0] wptr_q;
  logic [DW-1:0] sym_tab_q [SYMBOL_LEN];

  logic wr_symbol, wr_ctrl, wr_gap;

  assign wr_symbol = set_stb && (set_addr == 8'(SR_SYMBOL));
  assign wr_ctrl   = set_stb && (set_addr == 8'(SR_CTRL));
  assign wr_gap    = set_stb && (set_addr == 8'(SR_GAP));

  // Control/gap registers and table write pointer; a control write rewinds the pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q <= 1'b0;
      gap_q    <= '0;
      wptr_q   <= '0;
    end else begin
      if (wr_ctrl) begin
        enable_q <= set_data[0];
        wptr_q   <= '0;
      end else if (wr_symbol) begin
        wptr_q <= (wptr_q == SW'(SYMBOL_LEN - 1)) ? '0 : SW'(wptr_q + 1'b1);
      end
      if (wr_gap) begin
        gap_q <= set_data[GW-1:0];
      end
    end
  end

  // Preamble table storage; deliberately not reset so contents survive reset
  always_ff @(posedge clk) begin
    if (wr_symbol) begin
      sym_tab_q[wptr_q] <= DW'(set_data);
    end
  end

  // FSM state and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sidx_q    <= '0;
      gcnt_q    <= '0;
      gap_lat_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sidx_q    <= sidx_d;
      gcnt_q    <= gcnt_d;
      gap_lat_q <= gap_lat_d;
    end
  end

  // Next-state and stream outputs; payload is a zero-latency pass-through
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sidx_d    = sidx_q;
    gcnt_d    = gcnt_q;
    gap_lat_d = gap_lat_q;
    o_tvalid  = 1'b0;
    o_tdata   = '0;
    o_tlast   = 1'b0;
    i_tready  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // enable is only looked at here, so it changes on frame boundaries
        if (i_tvalid) begin
          state_d = enable_q ? S_PREAMBLE : S_PAYLOAD;
        end
      end

      S_PREAMBLE: begin
        // sidx tracks cnt mod SYMBOL_LEN without a divider
        o_tvalid = 1'b1;
        o_tdata  = sym_tab_q[sidx_q];
        if (o_tready) begin
          if (cnt_q == CW'(PREAMBLE_LEN - 1)) begin
            cnt_d   = '0;
            sidx_d  = '0;
            state_d = S_PAYLOAD;
          end else begin
            cnt_d  = CW'(cnt_q + 1'b1);
            sidx_d = (sidx_q == SW'(SYMBOL_LEN - 1)) ? '0 : SW'(sidx_q + 1'b1);
          end
        end
      end

      S_PAYLOAD: begin
        o_tvalid = i_tvalid;
        o_tdata  = i_tdata;
        o_tlast  = i_tlast;
        i_tready = o_tready;
        if (i_tvalid && o_tready && i_tlast) begin
          if (gap_q != '0) begin
            // snapshot the gap so later writes cannot shorten this one
            gap_lat_d = gap_q;
            gcnt_d    = '0;
            state_d   = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_GAP: begin
        o_tvalid = 1'b1;
        o_tlast  = (gcnt_q == GW'(gap_lat_q - 1'b1));
        if (o_tready) begin
          if (gcnt_q == GW'(gap_lat_q - 1'b1)) begin
            gcnt_d  = '0;
            state_d = S_IDLE;
          end else begin
            gcnt_d = GW'(gcnt_q + 1'b1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
